// File: rtl/write_data_pkg.sv
`default_nettype none
// ============================================================================
// Module   : write_data_pkg
// Brief    : Shared constants and helpers for the byte-merging write-data path.
// Revision : 1.0 - initial release
// ============================================================================
package write_data_pkg;

    localparam int          c_DATA_WIDTH = 32;
    localparam int          c_BYTE_WIDTH = 8;
    localparam logic [7:0]  c_LANE_RESET = 8'h00;

    // One strobe per byte of the data bus.
    function automatic int strb_width(input int data_width);
        return data_width / c_BYTE_WIDTH;
    endfunction

endpackage
`default_nettype wire

// File: rtl/write_data_byte_lane.sv
`default_nettype none
// ============================================================================
// Module   : wdata_byte_lane
// Brief    : Single 8-bit data lane; loads on enable, holds otherwise.
// Revision : 1.0 - initial release
// ============================================================================
module wdata_byte_lane
    import write_data_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic [7:0] i_data,
    output logic [7:0] o_data
);

    logic [7:0] r_data;

    // An unknown enable falls into the hold branch, so X handshakes never corrupt the lane.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= c_LANE_RESET;
        end else if (i_en) begin
            r_data <= i_data;
        end
    end

    assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/write_data.sv
`default_nettype none
// ============================================================================
// Module   : write_data
// Brief    : Registered write-data word with per-byte strobe merging.
// Revision : 1.0 - initial release
// ============================================================================
module write_data
    import write_data_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int STRB_WIDTH = strb_width(DATA_WIDTH)
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  WVALID,
    input  logic                  WREADY,
    input  logic [DATA_WIDTH-1:0] i_WDATA,
    output logic [DATA_WIDTH-1:0] o_WDATA,
    input  logic [STRB_WIDTH-1:0] WSTRB
);

    logic w_xfer;

    // ARESETn is active-high despite its name.
    assign w_xfer = WVALID & WREADY;

    generate
        if ((DATA_WIDTH % c_BYTE_WIDTH) != 0) begin : g_bad_data_width
            $error("write_data: DATA_WIDTH (%0d) must be a multiple of 8", DATA_WIDTH);
        end
        if (STRB_WIDTH != strb_width(DATA_WIDTH)) begin : g_bad_strb_width
            $error("write_data: STRB_WIDTH (%0d) must equal DATA_WIDTH/8", STRB_WIDTH);
        end
    endgenerate

    generate
        for (genvar i = 0; i < STRB_WIDTH; i++) begin : g_lane
            wdata_byte_lane u_lane (
                .clk    (ACLK),
                .rst    (ARESETn),
                .i_en   (w_xfer & WSTRB[i]),
                .i_data (i_WDATA[i*c_BYTE_WIDTH +: c_BYTE_WIDTH]),
                .o_data (o_WDATA[i*c_BYTE_WIDTH +: c_BYTE_WIDTH])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_write_data.sv
`default_nettype none
// ============================================================================
// Module   : tb_write_data
// Brief    : Directed self-checking bench for write_data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_write_data;

    logic        ACLK;
    logic        ARESETn;
    logic        WVALID;
    logic        WREADY;
    logic [31:0] i_WDATA;
    logic [31:0] o_WDATA;
    logic [3:0]  WSTRB;

    int r_tests;
    int r_fails;

    write_data u_dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .i_WDATA (i_WDATA),
        .o_WDATA (o_WDATA),
        .WSTRB   (WSTRB)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        r_tests++;
        if (obs !== exp) begin
            r_fails++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, return just after the rising edge.
    task automatic drive(input logic v, input logic r, input logic [3:0] s, input logic [31:0] d);
        @(negedge ACLK);
        WVALID  = v;
        WREADY  = r;
        WSTRB   = s;
        i_WDATA = d;
        @(posedge ACLK);
        #1;
    endtask

    task automatic pulse_reset();
        ARESETn = 1'b1;
        #1;
        check("async_reset", o_WDATA, 32'h0000_0000);
        #1;
        ARESETn = 1'b0;
    endtask

    logic [3:0]  walk_strb [8];
    logic [31:0] walk_exp  [8];

    initial begin
        r_tests = 0;
        r_fails = 0;
        walk_strb = '{4'b1000, 4'b0100, 4'b1100, 4'b0010, 4'b0001, 4'b0110, 4'b0011, 4'b1111};
        walk_exp  = '{32'hFF000000, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFFFF00,
                      32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};

        ARESETn = 1'b0;
        WVALID  = 1'b0;
        WREADY  = 1'b0;
        WSTRB   = 4'b0000;
        i_WDATA = 32'h0;
        #1;
        ARESETn = 1'b1;
        #1;
        check("reset_no_clock", o_WDATA, 32'h0000_0000);

        // Full handshake while reset is held must be ignored.
        drive(1'b1, 1'b1, 4'b1111, 32'hFFFF_FFFF);
        check("reset_blocks_xfer", o_WDATA, 32'h0000_0000);
        @(negedge ACLK);
        ARESETn = 1'b0;
        WVALID  = 1'b0;
        WREADY  = 1'b0;

        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, walk_strb[i], 32'hFFFF_FFFF);
            check($sformatf("strobe_walk_%0d", i), o_WDATA, walk_exp[i]);
        end

        pulse_reset();
        drive(1'b1, 1'b1, 4'b1010, 32'h1234_5678);
        check("lane_iso_1010", o_WDATA, 32'h1200_5600);
        drive(1'b1, 1'b1, 4'b0101, 32'hAABB_CCDD);
        check("lane_iso_0101", o_WDATA, 32'h12BB_56DD);

        drive(1'b1, 1'b0, 4'b1111, 32'h0);
        check("gate_no_ready", o_WDATA, 32'h12BB_56DD);
        drive(1'b0, 1'b1, 4'b1111, 32'h0);
        check("gate_no_valid", o_WDATA, 32'h12BB_56DD);
        drive(1'b1, 1'b1, 4'b0000, 32'h0);
        check("gate_zero_strb", o_WDATA, 32'h12BB_56DD);
        drive(1'b1, 1'bx, 4'b1111, 32'h0);
        check("gate_x_ready", o_WDATA, 32'h12BB_56DD);

        // Inputs changing between edges must not reach the output.
        @(negedge ACLK);
        WVALID  = 1'b1;
        WREADY  = 1'b1;
        WSTRB   = 4'b1111;
        i_WDATA = 32'hFFFF_FFFF;
        #2;
        check("no_comb_path", o_WDATA, 32'h12BB_56DD);
        @(posedge ACLK);
        #1;
        check("one_cycle_latency", o_WDATA, 32'hFFFF_FFFF);

        pulse_reset();
        drive(1'b1, 1'b1, 4'b0001, 32'h0000_00A5);
        check("post_reset_merge", o_WDATA, 32'h0000_00A5);
        drive(1'b1, 1'b1, 4'b0100, 32'h0077_0000);
        check("back_to_back", o_WDATA, 32'h0077_00A5);
        drive(1'b0, 1'b0, 4'b0000, 32'h0);

        $display("[TB] %0d tests run, %0d failed", r_tests, r_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/write_data.md
WRITE_DATA -- requirements
Module: write_data

Interface
REQ-001 Parameter DATA_WIDTH, default 32: data bus width in bits; SHALL be a multiple of 8.
REQ-002 Parameter STRB_WIDTH, default DATA_WIDTH/8: number of byte lanes; SHALL not be overridden independently.
REQ-003 Port order SHALL be ACLK, ARESETn, WVALID, WREADY, i_WDATA, o_WDATA, WSTRB, to support positional instantiation.
REQ-004 ACLK  input  1  single clock; all state updates on the rising edge.
REQ-005 ARESETn  input  1  asynchronous reset, active-high despite the name: 1 = reset asserted.
REQ-006 WVALID  input  1  write-data valid from the master.
REQ-007 WREADY  input  1  write-data ready from the slave side.
REQ-008 i_WDATA  input  DATA_WIDTH  incoming write data.
REQ-009 o_WDATA  output  DATA_WIDTH  registered, byte-merged data word.
REQ-010 WSTRB  input  STRB_WIDTH  byte-lane strobes; bit i qualifies i_WDATA[8i+7:8i].

Function
REQ-011 A transfer SHALL occur on a rising ACLK edge only when WVALID==1 and WREADY==1, with reset deasserted.
REQ-012 Transfer behaviour, per lane i:
- WSTRB[i]==1: o_WDATA[8i+7:8i] takes i_WDATA[8i+7:8i].
- WSTRB[i]==0: lane holds its previous value.
REQ-013 With no transfer (either handshake signal 0 or unknown), every lane of o_WDATA SHALL hold.
REQ-014 Latency SHALL be one cycle: merged data is visible on o_WDATA immediately after the transferring edge; there is no combinational path from inputs to o_WDATA.
REQ-015 A transfer with WSTRB all-zero SHALL complete the handshake with no change to o_WDATA.
REQ-016 Each lane SHALL update independently; any strobe pattern, including non-contiguous patterns such as 4'b1010, SHALL be legal.
REQ-017 Consecutive back-to-back transfers on every cycle SHALL be supported, with each merge applied to the result of the previous one.
REQ-018 The block SHALL not drive or modify WREADY; handshake generation is external.
REQ-019 There SHALL be no state machine; the only state is the DATA_WIDTH-bit data register.

Reset
REQ-020 When ARESETn==1, o_WDATA SHALL go to all zeros immediately, without waiting for a clock edge.
REQ-021 While ARESETn==1, transfers SHALL be ignored, even with WVALID, WREADY and WSTRB all asserted.
REQ-022 After ARESETn falls, the first rising edge satisfying REQ-011 SHALL perform a normal merge onto the zero value.
REQ-023 A reset asserted mid-stream SHALL discard all previously merged bytes.

Structure
REQ-024 A shared package SHALL hold:
- the DATA_WIDTH default (32);
- the byte width constant (8);
- the STRB_WIDTH derivation function;
- the reset-value constant (all zeros).
REQ-025 One sub-module, wdata_byte_lane, SHALL implement a single 8-bit lane with async reset, an enable equal to WVALID&WREADY&WSTRB[i], and hold-otherwise behaviour.
REQ-026 write_data SHALL instantiate STRB_WIDTH copies of wdata_byte_lane via a generate loop.
REQ-027 write_data SHALL add a parameter-legality check that flags DATA_WIDTH%8!=0 at elaboration.

Verification
REQ-028 Reset check: ARESETn=1 with no clock edge -> o_WDATA==32'h00000000; WVALID=WREADY=1, WSTRB=4'b1111 during reset -> o_WDATA remains 0.
REQ-029 Strobe walk: i_WDATA=32'hFFFFFFFF, one transfer per cycle from reset value 0:
- WSTRB=1000 -> FF000000
- 0100 -> FFFF0000
- 1100 -> FFFF0000
- 0010 -> FFFFFF00
- 0001 -> FFFFFFFF
- 0110 -> FFFFFFFF
- 0011 -> FFFFFFFF
- 1111 -> FFFFFFFF
REQ-030 Lane isolation: from 0, i_WDATA=32'h12345678 with WSTRB=1010 -> 12005600; then i_WDATA=32'hAABBCCDD with WSTRB=0101 -> 12BB56DD.
REQ-031 Handshake gating: o_WDATA=32'h12BB56DD, i_WDATA=32'h0, WSTRB=1111:
- WVALID=1, WREADY=0 -> unchanged;
- WVALID=0, WREADY=1 -> unchanged;
- WVALID=1, WREADY=1 with WSTRB=0000 -> unchanged.
REQ-032 Mid-stream reset: from o_WDATA=32'hFFFFFFFF, pulse ARESETn=1 between clock edges -> o_WDATA=0 at once; next transfer with WSTRB=0001, i_WDATA=32'h000000A5 -> 000000A5.
